spi_reg_bank: RTL and testbench

//   Parametrised SPI mode-0 peripheral with a writable and readable register bank.

---
 rtl/spi_reg_bank.sv | 258 +++++++++++++++++++++++++
 tb/tb_spi_reg_bank.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_bank.sv
// spi_reg_bank
//   SPI mode-0 peripheral with a read/write register bank. Every frame is
//   {rw, addr, data}, sent MSB first; rw=1 writes, rw=0 reads back on cipo.
//   Frames of the wrong length, and writes to addresses that do not exist,
//   are dropped and counted in a saturating error counter.
//
// Ports
//   clk        system clock
//   rst        synchronous reset, active high
//   sclk       SPI clock (asynchronous to clk)
//   copi       SPI data in
//   ncs        SPI chip select, active low
//   cipo       SPI data out (read frames)
//   cipo_oe    cipo output enable
//   regs_flat  register i at [i*DATA_W +: DATA_W]
//   wr_strobe  one-cycle pulse on the register that was just written
//   err_count  saturating count of rejected frames
//
// States
//   state     | meaning
//   ----------+---------------------------------------------------------
//   ST_IDLE   | waiting for a falling edge on ncs
//   ST_SHIFT  | frame in progress: shifting copi, driving cipo on reads
//   ST_COMMIT | one cycle: write the captured data and pulse wr_strobe

module spi_reg_bank #(
   parameter int NUM_REGS    = 5,
   parameter int DATA_W      = 8,
   parameter int ADDR_W      = 7,
   parameter int SYNC_STAGES = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         sclk,
   input  logic                         copi,
   input  logic                         ncs,
   output logic                         cipo,
   output logic                         cipo_oe,
   output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
   output logic [NUM_REGS-1:0]          wr_strobe,
   output logic [7:0]                   err_count
);

   localparam int FRAME = 1 + ADDR_W + DATA_W;
   localparam int CNT_W = $clog2(FRAME + 2);
   localparam int ARM_W = $clog2(SYNC_STAGES + 1);

   localparam logic [CNT_W-1:0]  CNT_FRAME  = CNT_W'(FRAME);
   localparam logic [CNT_W-1:0]  CNT_SAT    = CNT_W'(FRAME + 1);
   // Count value just before the edge that completes the rw+addr header.
   localparam logic [CNT_W-1:0]  CNT_HDR    = CNT_W'(ADDR_W);
   localparam logic [ADDR_W:0]   ADDR_LIMIT = (ADDR_W + 1)'(NUM_REGS);
   localparam logic [ARM_W-1:0]  ARM_DONE   = ARM_W'(SYNC_STAGES);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_COMMIT
   } state_t;

   state_t state, state_nxt;

   logic [SYNC_STAGES-1:0] sclk_sync, copi_sync, ncs_sync;
   logic                   sclk_s, copi_s, ncs_s;
   logic                   sclk_prev, ncs_prev;
   logic                   sclk_rise, sclk_fall, ncs_rise, ncs_fall;

   logic [ARM_W-1:0]       arm_cnt;
   logic                   armed;

   logic [CNT_W-1:0]       bit_cnt;
   logic [FRAME-1:0]       shift_reg;
   logic [FRAME-1:0]       sr_next;
   logic [DATA_W-1:0]      rd_shadow;
   logic [DATA_W-1:0]      rd_val;
   logic [ADDR_W-1:0]      addr_q;
   logic [DATA_W-1:0]      data_q;

   logic                   frm_rw;
   logic [ADDR_W-1:0]      frm_addr;
   logic [DATA_W-1:0]      frm_data;
   logic                   frame_ok;
   logic                   addr_bad;
   logic                   frm_reject;

   logic [DATA_W-1:0]      regs [NUM_REGS];

   // Synchronisers; presets make an idle bus look like sclk=0, ncs=1.
   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_sync <= '0;
         copi_sync <= '0;
         ncs_sync  <= '1;
         sclk_prev <= 1'b0;
         ncs_prev  <= 1'b1;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
         copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi};
         ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs};
         sclk_prev <= sclk_s;
         ncs_prev  <= ncs_s;
      end
   end

   assign sclk_s = sclk_sync[SYNC_STAGES-1];
   assign copi_s = copi_sync[SYNC_STAGES-1];
   assign ncs_s  = ncs_sync[SYNC_STAGES-1];

   assign sclk_rise = ~sclk_prev & sclk_s;
   assign sclk_fall = sclk_prev & ~sclk_s;
   assign ncs_rise  = ~ncs_prev & ncs_s;
   // The preset ncs=1 would turn a chip select already held low at reset
   // release into a fake falling edge. Edges are only honoured once the
   // synchroniser has flushed and ncs has really been seen high.
   assign ncs_fall  = armed & ncs_prev & ~ncs_s;

   always_ff @(posedge clk) begin
      if (rst) begin
         arm_cnt <= '0;
         armed   <= 1'b0;
      end else if (arm_cnt != ARM_DONE) begin
         arm_cnt <= arm_cnt + ARM_W'(1);
      end else if (ncs_s) begin
         armed   <= 1'b1;
      end
   end

   // Frame decode. With exactly FRAME bits shifted in, shift_reg holds the
   // frame as sent, so the fields sit at fixed positions.
   assign sr_next    = {shift_reg[FRAME-2:0], copi_s};
   assign frm_rw     = shift_reg[FRAME-1];
   assign frm_addr   = shift_reg[FRAME-2 -: ADDR_W];
   assign frm_data   = shift_reg[DATA_W-1:0];
   assign frame_ok   = (bit_cnt == CNT_FRAME);
   assign addr_bad   = ({1'b0, frm_addr} >= ADDR_LIMIT);
   assign frm_reject = ~frame_ok | (frm_rw & addr_bad);

   // Read mux for the header-completing edge; addresses that do not exist read 0.
   always_comb begin
      rd_val = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (sr_next[ADDR_W-1:0] == ADDR_W'(i)) begin
            rd_val = regs[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      wr_strobe = '0;
      case (state)
         ST_IDLE: begin
            if (ncs_fall) begin
               state_nxt = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (ncs_rise) begin
               if (!frm_reject && frm_rw) begin
                  state_nxt = ST_COMMIT;
               end else begin
                  state_nxt = ST_IDLE;
               end
            end
         end
         ST_COMMIT: begin
            state_nxt = ST_IDLE;
            for (int i = 0; i < NUM_REGS; i++) begin
               if (addr_q == ADDR_W'(i)) begin
                  wr_strobe[i] = 1'b1;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt   <= '0;
         shift_reg <= '0;
         rd_shadow <= '0;
         addr_q    <= '0;
         data_q    <= '0;
         cipo      <= 1'b0;
         cipo_oe   <= 1'b0;
         err_count <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (ncs_fall) begin
                  bit_cnt   <= '0;
                  shift_reg <= '0;
                  rd_shadow <= '0;
                  cipo      <= 1'b0;
                  cipo_oe   <= 1'b0;
               end
            end
            ST_SHIFT: begin
               // ncs rising wins over any sclk edge seen in the same cycle.
               if (ncs_rise) begin
                  cipo    <= 1'b0;
                  cipo_oe <= 1'b0;
                  addr_q  <= frm_addr;
                  data_q  <= frm_data;
                  if (frm_reject && err_count != 8'hFF) begin
                     err_count <= err_count + 8'd1;
                  end
               end else begin
                  if (sclk_rise) begin
                     shift_reg <= sr_next;
                     if (bit_cnt != CNT_SAT) begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                     end
                     if (bit_cnt == CNT_HDR && !sr_next[ADDR_W]) begin
                        rd_shadow <= rd_val;
                        cipo_oe   <= 1'b1;
                     end
                  end
                  if (sclk_fall && cipo_oe) begin
                     cipo      <= rd_shadow[DATA_W-1];
                     rd_shadow <= {rd_shadow[DATA_W-2:0], 1'b0};
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (state == ST_COMMIT) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (addr_q == ADDR_W'(i)) begin
               regs[i] <= data_q;
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
      assign regs_flat[g*DATA_W +: DATA_W] = regs[g];
   end

endmodule

// File: tb/tb_spi_reg_bank.sv
// Bench for spi_reg_bank: a default instance (5 x 8-bit regs, 7-bit addr) and
// a wide instance (8 x 16-bit regs, 3-bit addr). A plain array model of the
// register contents, error counts and strobe counts gives the expected values.

module tb_spi_reg_bank;

   localparam int H = 8;   // sclk half period in clk cycles

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic sclk = 1'b0;
   logic copi = 1'b0;
   logic ncs0 = 1'b0;
   logic ncs1 = 1'b1;

   logic        cipo0, oe0, cipo1, oe1;
   logic [39:0] rf0;
   logic [4:0]  ws0;
   logic [7:0]  ec0;
   logic [127:0] rf1;
   logic [7:0]  ws1;
   logic [7:0]  ec1;

   always #5 clk = ~clk;

   spi_reg_bank u0 (
      .clk(clk), .rst(rst), .sclk(sclk), .copi(copi), .ncs(ncs0),
      .cipo(cipo0), .cipo_oe(oe0), .regs_flat(rf0), .wr_strobe(ws0), .err_count(ec0)
   );

   spi_reg_bank #(.NUM_REGS(8), .DATA_W(16), .ADDR_W(3), .SYNC_STAGES(3)) u1 (
      .clk(clk), .rst(rst), .sclk(sclk), .copi(copi), .ncs(ncs1),
      .cipo(cipo1), .cipo_oe(oe1), .regs_flat(rf1), .wr_strobe(ws1), .err_count(ec1)
   );

   int st_cnt0 [5];
   int st_cnt1 [8];

   always @(negedge clk) begin
      for (int i = 0; i < 5; i++) st_cnt0[i] += int'(ws0[i]);
      for (int i = 0; i < 8; i++) st_cnt1[i] += int'(ws1[i]);
   end

   int m0 [5];
   int m1 [8];
   int e0, e1;
   int exp_st0 [5];
   int exp_st1 [8];

   int n_assert = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive one frame on instance d. Sends nclk sclk pulses; bits past the
   // frame width are 0. rst_after>0 pulses rst after that many bits and
   // abandons the frame. rd collects cipo sampled just before each data-bit
   // rising edge; oe_bad counts those samples where cipo_oe was low.
   task automatic xfer(input int d, input logic [31:0] frame, input int nclk,
                       input int rst_after, output logic [31:0] rd, output int oe_bad);
      int fw, aw;
      fw = (d == 0) ? 16 : 20;
      aw = (d == 0) ? 7 : 3;
      rd = '0;
      oe_bad = 0;
      if (d == 0) ncs0 = 1'b0; else ncs1 = 1'b0;
      repeat (H) @(negedge clk);
      for (int k = 0; k < nclk; k++) begin
         copi = (k < fw) ? frame[fw-1-k] : 1'b0;
         repeat (H) @(negedge clk);
         if (k > aw && k < fw) begin
            rd = {rd[30:0], (d == 0) ? cipo0 : cipo1};
            if (((d == 0) ? oe0 : oe1) !== 1'b1) oe_bad++;
         end
         sclk = 1'b1;
         repeat (H) @(negedge clk);
         sclk = 1'b0;
         if (rst_after == k + 1) begin
            @(negedge clk);
            rst = 1'b1;
            repeat (3) @(negedge clk);
            rst = 1'b0;
            break;
         end
      end
      repeat (H) @(negedge clk);
      if (d == 0) ncs0 = 1'b1; else ncs1 = 1'b1;
      repeat (14) @(negedge clk);
   endtask

   task automatic check_all(input int d);
      if (d == 0) begin
         for (int i = 0; i < 5; i++) begin
            chk($sformatf("u0_reg%0d", i), {24'd0, rf0[i*8 +: 8]}, m0[i]);
            chk($sformatf("u0_strobe%0d", i), st_cnt0[i], exp_st0[i]);
         end
         chk("u0_err_count", {24'd0, ec0}, e0);
      end else begin
         for (int i = 0; i < 8; i++) begin
            chk($sformatf("u1_reg%0d", i), {16'd0, rf1[i*16 +: 16]}, m1[i]);
            chk($sformatf("u1_strobe%0d", i), st_cnt1[i], exp_st1[i]);
         end
         chk("u1_err_count", {24'd0, ec1}, e1);
      end
   endtask

   // Full transaction: drive, apply the protocol rules to the model, check.
   task automatic do_frame(input int d, input int rw, input int addr, input int data, input int nclk);
      int fw, dw, nregs, oe_bad, exp_rd;
      logic [31:0] frame, rd;
      fw    = (d == 0) ? 16 : 20;
      dw    = (d == 0) ? 8 : 16;
      nregs = (d == 0) ? 5 : 8;
      frame = (rw << (fw - 1)) | (addr << dw) | data;
      xfer(d, frame, nclk, 0, rd, oe_bad);
      if (nclk != fw || (rw == 1 && addr >= nregs)) begin
         if (d == 0) e0 = (e0 < 255) ? e0 + 1 : 255;
         else        e1 = (e1 < 255) ? e1 + 1 : 255;
      end else if (rw == 1) begin
         if (d == 0) begin m0[addr] = data; exp_st0[addr]++; end
         else        begin m1[addr] = data; exp_st1[addr]++; end
      end else begin
         exp_rd = (addr >= nregs) ? 0 : ((d == 0) ? m0[addr] : m1[addr]);
         chk($sformatf("u%0d_read_a%0d", d, addr), rd, exp_rd);
         chk($sformatf("u%0d_read_oe", d), oe_bad, 0);
      end
      chk($sformatf("u%0d_oe_after", d), {31'd0, (d == 0) ? oe0 : oe1}, 0);
      check_all(d);
   endtask

   initial begin
      logic [31:0] rd;
      int oe_bad, d, nclk, fw, nregs, sel;

      for (int i = 0; i < 5; i++) begin m0[i] = 0; exp_st0[i] = 0; end
      for (int i = 0; i < 8; i++) begin m1[i] = 0; exp_st1[i] = 0; end
      e0 = 0;
      e1 = 0;

      // Reset with u0's chip select already low.
      rst  = 1'b1;
      ncs0 = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("u0_cipo_reset", {31'd0, cipo0}, 0);
      chk("u0_oe_reset", {31'd0, oe0}, 0);
      check_all(0);
      check_all(1);

      // A frame clocked while ncs has been low since reset must be ignored.
      xfer(0, 32'h80FF, 16, 0, rd, oe_bad);
      check_all(0);

      // Write, readback, out-of-range write, bad lengths.
      do_frame(0, 1, 0, 'hA5, 16);
      do_frame(0, 1, 4, 'h3C, 16);
      do_frame(0, 0, 4, 0, 16);
      do_frame(0, 1, 5, 'hFF, 16);
      do_frame(0, 1, 0, 'h11, 12);
      do_frame(0, 1, 0, 'h22, 17);
      do_frame(0, 0, 100, 0, 16);

      // Reset in the middle of a write, then a normal write.
      xfer(0, 32'h8177, 16, 9, rd, oe_bad);
      for (int i = 0; i < 5; i++) m0[i] = 0;
      for (int i = 0; i < 8; i++) m1[i] = 0;
      e0 = 0;
      e1 = 0;
      check_all(0);
      check_all(1);
      do_frame(0, 1, 1, 'h77, 16);

      // Wide instance.
      do_frame(1, 1, 7, 'hBEEF, 20);
      do_frame(1, 0, 7, 0, 20);

      // Random traffic on both instances.
      for (int n = 0; n < 36; n++) begin
         d     = int'($urandom_range(0, 1));
         fw    = (d == 0) ? 16 : 20;
         nregs = (d == 0) ? 5 : 8;
         sel   = int'($urandom_range(0, 9));
         nclk  = (sel < 8) ? fw : ((sel == 8) ? fw - 2 : fw + 1);
         do_frame(d, int'($urandom_range(0, 1)),
                  (d == 0) ? int'($urandom_range(0, nregs)) : int'($urandom_range(0, 7)),
                  (d == 0) ? int'($urandom & 32'hFF) : int'($urandom & 32'hFFFF),
                  nclk);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
